booth_mul_sequencer: RTL and testbench

Upstream issue/capture stage for the radix-4 Booth multiplier. It buffers signed operand pairs in a small FIFO and drives the multiplier's start/M/Q_in handshake. It captures the product when the multiplier signals ready and presents it downstream on a valid/ready interface. It hides the multiplier's level-sensitive start/ready protocol from the rest of the ALU.

---
 rtl/booth_mul_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_booth_mul_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_sequencer.sv
// booth_mul_sequencer: issue/capture stage in front of a radix-4 Booth multiplier.
// Buffers signed operand pairs in a DEPTH-entry FIFO, drives the multiplier's
// level-sensitive start/ready handshake and holds each product on a
// valid/ready output register.
// Optional build macro: MUL_ZERO_BYPASS_EN (pairs with a zero operand produce
// a zero product directly, without running the multiplier).
module booth_mul_sequencer #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p,
  output logic           mul_start,
  output logic [W-1:0]   mul_m,
  output logic [W-1:0]   mul_q,
  input  logic           mul_ready,
  input  logic [2*W-1:0] mul_p,
  output logic           busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [2*W-1:0]  out_p_q, out_p_d;
  logic            mul_start_q, mul_start_d;
  logic [W-1:0]    mul_m_q, mul_m_d;
  logic [W-1:0]    mul_q_q, mul_q_d;
  logic            busy_q, busy_d;

  // Operand storage: {a, b} per entry.
  logic [2*W-1:0]  mem_q [DEPTH];

  logic            push;
  logic            pop;
  logic [W-1:0]    head_a;
  logic [W-1:0]    head_b;

  assign push   = in_valid && in_ready_q;
  assign head_a = mem_q[rd_ptr_q][2*W-1:W];
  assign head_b = mem_q[rd_ptr_q][W-1:0];

  // Sequencer: pop in IDLE, hold start through ISSUE, wait out stale ready in DRAIN.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    out_valid_d = out_valid_q;
    out_p_d     = out_p_q;
    mul_start_d = mul_start_q;
    mul_m_d     = mul_m_q;
    mul_q_d     = mul_q_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if ((count_q != '0) && !out_valid_q && !mul_ready) begin
          pop = 1'b1;
`ifdef MUL_ZERO_BYPASS_EN
          if ((head_a == '0) || (head_b == '0)) begin
            out_p_d     = '0;
            out_valid_d = 1'b1;
          end else begin
            mul_m_d     = head_a;
            mul_q_d     = head_b;
            mul_start_d = 1'b1;
            state_d     = ISSUE;
          end
`else
          mul_m_d     = head_a;
          mul_q_d     = head_b;
          mul_start_d = 1'b1;
          state_d     = ISSUE;
`endif
        end
      end
      ISSUE: begin
        if (mul_ready) begin
          out_p_d     = mul_p;
          out_valid_d = 1'b1;
          mul_start_d = 1'b0;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (!mul_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO bookkeeping; in_ready and busy are registered from next-state values
  // so they reflect the block's state in the same cycle as the other outputs.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d != FULL_CNT);
    busy_d     = (state_d != IDLE) || (count_d != '0);
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      mul_start_q <= 1'b0;
      mul_m_q     <= '0;
      mul_q_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
      mul_start_q <= mul_start_d;
      mul_m_q     <= mul_m_d;
      mul_q_q     <= mul_q_d;
      busy_q      <= busy_d;
    end
  end

  // Operand storage write port; contents are only meaningful under count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_a, in_b};
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign mul_start = mul_start_q;
  assign mul_m     = mul_m_q;
  assign mul_q     = mul_q_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Bench for booth_mul_sequencer: a behavioural radix-4 multiplier responder,
// directed stimulus with hand-computed products, and a scoreboard monitor.
module tb_booth_mul_sequencer;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;
  logic           mul_start;
  logic [W-1:0]   mul_m;
  logic [W-1:0]   mul_q;
  logic           mul_ready;
  logic [2*W-1:0] mul_p;
  logic           busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int delivered = 0;

  logic [2*W-1:0] exp_q [$];

  booth_mul_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .mul_start (mul_start),
    .mul_m     (mul_m),
    .mul_q     (mul_q),
    .mul_ready (mul_ready),
    .mul_p     (mul_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier responder: loads on start, W/2 iteration edges, then holds
  // ready until start is seen low.
  logic              m_run;
  int                m_cnt;
  logic signed [15:0] m_a;
  logic signed [15:0] m_b;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run     <= 1'b0;
      m_cnt     <= 0;
      m_a       <= '0;
      m_b       <= '0;
      mul_ready <= 1'b0;
      mul_p     <= '0;
    end else if (m_run) begin
      if (m_cnt == 1) begin
        m_run     <= 1'b0;
        mul_ready <= 1'b1;
        mul_p     <= m_a * m_b;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (mul_ready) begin
      if (!mul_start) mul_ready <= 1'b0;
    end else if (mul_start) begin
      m_run <= 1'b1;
      m_cnt <= W / 2;
      m_a   <= 16'(signed'(mul_m));
      m_b   <= 16'(signed'(mul_q));
    end
  end

  // Start-edge tracking: issues must never start while ready is still high.
  logic start_prev = 1'b0;
  logic start_seen = 1'b0;
  int   start_rises = 0;
  int   start_viol  = 0;
  int   rise_cyc    = 0;
  int   prev_rise_cyc = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (mul_start && !start_prev) begin
        start_rises   = start_rises + 1;
        prev_rise_cyc = rise_cyc;
        rise_cyc      = cyc;
        if (mul_ready) start_viol = start_viol + 1;
      end
      if (mul_start) start_seen = 1'b1;
    end
    start_prev = mul_start;
  end

  // Scoreboard monitor: every accepted product is compared in order.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL out_p_unexpected act=%h req=none", out_p);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        if (out_p !== e) begin
          failures = failures + 1;
          $display("FAIL out_p[%0d] act=%h req=%h", delivered, out_p, e);
        end
      end
      delivered = delivered + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair, waiting for in_ready; returns #1 after the push edge.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W-1:0] req);
    int t = 0;
    while (!in_ready && t < 300) begin
      tick();
      t++;
    end
    if (t >= 300) chk("push_timeout", 32'(t), 32'(0));
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    exp_q.push_back(req);
    tick();
    in_valid = 1'b0;
  endtask

  // Edges from the push edge (counted as 1) until out_valid is seen.
  task automatic latency(output int n);
    n = 1;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || busy || out_valid) && t < 500) begin
      tick();
      t++;
    end
    chk(name, 32'(t < 500), 32'(1));
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_in_ready",  32'(in_ready),  32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_p",     32'(out_p),     32'(0));
    chk("rst_mul_start", 32'(mul_start), 32'(0));
    chk("rst_mul_m",     32'(mul_m),     32'(0));
    chk("rst_mul_q",     32'(mul_q),     32'(0));
    chk("rst_busy",      32'(busy),      32'(0));
    rst = 1'b0;
    tick();

    // Single product and latency
    start_seen = 1'b0;
    push(8'h03, 8'hFB, 16'hFFF1);
    chk("t1_busy_after_push", 32'(busy), 32'(1));
    tick();
    chk("t1_start", 32'(mul_start), 32'(1));
    chk("t1_mul_m", 32'(mul_m), 32'(8'h03));
    chk("t1_mul_q", 32'(mul_q), 32'(8'hFB));
    latency(n);
    chk("t1_latency", 32'(n + 1), 32'(8));
    chk("t1_start_seen", 32'(start_seen), 32'(1));
    wait_idle("t1_idle");
    chk("t1_busy_idle", 32'(busy), 32'(0));

    // Two back-to-back extremes; second issue must wait for ready low
    start_rises = 0;
    start_viol  = 0;
    push(8'h80, 8'h80, 16'h4000);
    push(8'h7F, 8'h80, 16'hC080);
    wait_idle("t2_idle");
    chk("t2_start_rises", 32'(start_rises), 32'(2));
    chk("t2_start_viol",  32'(start_viol),  32'(0));
    chk("t2_issue_period", 32'(rise_cyc - prev_rise_cyc), 32'(W / 2 + 5));

    // Backpressure: 1 issued + DEPTH buffered, then full
    out_ready = 1'b0;
    push(8'h01, 8'h01, 16'h0001);
    push(8'hFF, 8'h01, 16'hFFFF);
    push(8'h0A, 8'hF6, 16'hFF9C);
    push(8'hF9, 8'hF7, 16'h003F);
    chk("t3_ready_before_full", 32'(in_ready), 32'(1));
    push(8'h32, 8'h32, 16'h09C4);
    chk("t3_in_ready_full", 32'(in_ready), 32'(0));
    repeat (12) tick();
    chk("t3_held_valid", 32'(out_valid), 32'(1));
    chk("t3_held_p",     32'(out_p),     32'(16'h0001));
    chk("t3_still_full", 32'(in_ready),  32'(0));
    out_ready = 1'b1;
    push(8'h9C, 8'h64, 16'hD8F0);
    wait_idle("t3_idle");

    // Reset while the multiplier is running
    push(8'h07, 8'h09, 16'h003F);
    n = 0;
    while (!mul_start && n < 20) begin
      tick();
      n++;
    end
    chk("t4_reached_issue", 32'(mul_start), 32'(1));
    tick();
    rst = 1'b1;
    #2;
    chk("t4_out_valid", 32'(out_valid), 32'(0));
    chk("t4_mul_start", 32'(mul_start), 32'(0));
    chk("t4_in_ready",  32'(in_ready),  32'(1));
    chk("t4_busy",      32'(busy),      32'(0));
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    push(8'h02, 8'h02, 16'h0004);
    wait_idle("t4_idle");

    // Zero operand
    start_seen = 1'b0;
    push(8'h00, 8'h4D, 16'h0000);
    latency(n);
`ifdef MUL_ZERO_BYPASS_EN
    chk("t5_zero_latency", 32'(n), 32'(2));
    wait_idle("t5_idle");
    chk("t5_start_seen", 32'(start_seen), 32'(0));
`else
    chk("t5_zero_latency", 32'(n), 32'(8));
    wait_idle("t5_idle");
    chk("t5_start_seen", 32'(start_seen), 32'(1));
`endif

    // Simultaneous push/pop with 3 buffered, then wrap over 2*DEPTH pushes
    out_ready = 1'b0;
    push(8'h05, 8'h06, 16'h001E);
    push(8'hFE, 8'h03, 16'hFFFA);
    push(8'h04, 8'hFC, 16'hFFF0);
    push(8'h0C, 8'h0C, 16'h0090);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk("t6_count3_before", 32'(dut.count_q), 32'(3));
    out_ready = 1'b1;
    tick();
    chk("t6_consumed", 32'(out_valid), 32'(0));
    out_ready = 1'b0;
    push(8'h09, 8'hFD, 16'hFFE5);
    chk("t6_count3_after", 32'(dut.count_q), 32'(3));
    chk("t6_issue_on_push", 32'(mul_start), 32'(1));
    out_ready = 1'b1;
    push(8'hFF, 8'hFF, 16'h0001);
    push(8'h64, 8'hFF, 16'hFF9C);
    push(8'hCE, 8'hFD, 16'h0096);
    wait_idle("t6_idle");
    chk("t6_sb_empty", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1);
  end

endmodule
